// File: rtl/rs_latch.sv
// rtl/rs_latch.sv - clocked RS storage element with complementary outputs and forbidden-input policy
module rs_latch #(
    parameter int unsigned SYNC_STAGES  = 0,
    parameter int unsigned INVALID_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic R,
    input  logic S,
    output logic Q,
    output logic Q_L,
    output logic INV,
    output logic INV_SEEN
);

    localparam int unsigned STAGES = (SYNC_STAGES > 3) ? 3 : SYNC_STAGES;

    localparam logic [1:0] POLICY_NOR   = 2'd0;
    localparam logic [1:0] POLICY_RESET = 2'd1;
    localparam logic [1:0] POLICY_SET   = 2'd2;

    // Out-of-range policy codes fall back to the NOR-latch behaviour.
    localparam logic [1:0] POLICY = (INVALID_MODE == 1) ? POLICY_RESET :
                                    (INVALID_MODE == 2) ? POLICY_SET   : POLICY_NOR;

    // Decoded {Rs, Ss} input pairs.
    localparam logic [1:0] PAIR_HOLD    = 2'b00;
    localparam logic [1:0] PAIR_SET     = 2'b01;
    localparam logic [1:0] PAIR_RESET   = 2'b10;
    localparam logic [1:0] PAIR_INVALID = 2'b11;

    logic r_sync;
    logic s_sync;

    generate
        if (STAGES == 0) begin : g_direct
            assign r_sync = R;
            assign s_sync = S;
        end else if (STAGES == 1) begin : g_single
            logic r_pipe;
            logic s_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe <= 1'b0;
                    s_pipe <= 1'b0;
                end else begin
                    r_pipe <= R;
                    s_pipe <= S;
                end
            end

            assign r_sync = r_pipe;
            assign s_sync = s_pipe;
        end else begin : g_chain
            // Multi-flop chain for asynchronous R/S; keep the flops together.
            (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_pipe;
            (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] s_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe <= '0;
                    s_pipe <= '0;
                end else begin
                    r_pipe[0] <= R;
                    s_pipe[0] <= S;
                    for (int k = 1; k < int'(STAGES); k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                        s_pipe[k] <= s_pipe[k-1];
                    end
                end
            end

            assign r_sync = r_pipe[STAGES-1];
            assign s_sync = s_pipe[STAGES-1];
        end
    endgenerate

    logic [1:0] pair;
    logic       state;
    logic       both_low;
    logic       q_l_reg;
    logic       inv_reg;
    logic       inv_seen_reg;

    assign pair = {r_sync, s_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= 1'b0;
            both_low     <= 1'b0;
            q_l_reg      <= 1'b1;
            inv_reg      <= 1'b0;
            inv_seen_reg <= 1'b0;
        end else begin
            case (pair)
                PAIR_HOLD: begin
                    // Leaving the NOR forbidden state always resolves to reset since state is 0.
                    both_low <= 1'b0;
                    q_l_reg  <= ~state;
                    inv_reg  <= 1'b0;
                end
                PAIR_SET: begin
                    state    <= 1'b1;
                    both_low <= 1'b0;
                    q_l_reg  <= 1'b0;
                    inv_reg  <= 1'b0;
                end
                PAIR_RESET: begin
                    state    <= 1'b0;
                    both_low <= 1'b0;
                    q_l_reg  <= 1'b1;
                    inv_reg  <= 1'b0;
                end
                default: begin
                    inv_reg      <= 1'b1;
                    inv_seen_reg <= 1'b1;
                    case (POLICY)
                        POLICY_RESET: begin
                            state    <= 1'b0;
                            both_low <= 1'b0;
                            q_l_reg  <= 1'b1;
                        end
                        POLICY_SET: begin
                            state    <= 1'b1;
                            both_low <= 1'b0;
                            q_l_reg  <= 1'b0;
                        end
                        default: begin
                            state    <= 1'b0;
                            both_low <= 1'b1;
                            q_l_reg  <= 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

    assign Q        = state;
    assign Q_L      = q_l_reg;
    assign INV      = inv_reg;
    assign INV_SEEN = inv_seen_reg;

endmodule

// File: tb/tb_rs_latch.sv
// tb/tb_rs_latch.sv - scoreboard bench for rs_latch across four parameter sets
module tb_rs_latch;

    logic clk = 1'b0;
    logic rst;
    logic R;
    logic S;

    logic [3:0] q_w;
    logic [3:0] ql_w;
    logic [3:0] inv_w;
    logic [3:0] seen_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rs_latch #(.SYNC_STAGES(0), .INVALID_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .R(R), .S(S),
        .Q(q_w[0]), .Q_L(ql_w[0]), .INV(inv_w[0]), .INV_SEEN(seen_w[0]));
    rs_latch #(.SYNC_STAGES(0), .INVALID_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .R(R), .S(S),
        .Q(q_w[1]), .Q_L(ql_w[1]), .INV(inv_w[1]), .INV_SEEN(seen_w[1]));
    rs_latch #(.SYNC_STAGES(0), .INVALID_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .R(R), .S(S),
        .Q(q_w[2]), .Q_L(ql_w[2]), .INV(inv_w[2]), .INV_SEEN(seen_w[2]));
    rs_latch #(.SYNC_STAGES(2), .INVALID_MODE(0)) dut3 (
        .clk(clk), .rst(rst), .R(R), .S(S),
        .Q(q_w[3]), .Q_L(ql_w[3]), .INV(inv_w[3]), .INV_SEEN(seen_w[3]));

    typedef struct {
        bit       q;
        bit       ql;
        bit       inv;
        bit       seen;
        bit [2:0] rp;
        bit [2:0] sp;
    } model_t;

    typedef struct {
        bit [3:0] q;
        bit [3:0] ql;
        bit [3:0] inv;
        bit [3:0] seen;
    } exp_t;

    int     mode_of [4] = '{0, 1, 2, 0};
    int     depth_of[4] = '{0, 0, 0, 2};
    model_t ms[4];
    exp_t   sbq[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rr, input bit r, input bit s);
        bit rs;
        bit ss;
        if (rr) begin
            ms[i].q = 0; ms[i].ql = 1; ms[i].inv = 0; ms[i].seen = 0;
            ms[i].rp = 0; ms[i].sp = 0;
            return;
        end
        rs = (depth_of[i] == 0) ? r : ms[i].rp[depth_of[i]-1];
        ss = (depth_of[i] == 0) ? s : ms[i].sp[depth_of[i]-1];
        ms[i].rp = {ms[i].rp[1:0], r};
        ms[i].sp = {ms[i].sp[1:0], s};
        ms[i].inv = rs & ss;
        if (rs & ss) begin
            ms[i].seen = 1;
            if (mode_of[i] == 1)      begin ms[i].q = 0; ms[i].ql = 1; end
            else if (mode_of[i] == 2) begin ms[i].q = 1; ms[i].ql = 0; end
            else                      begin ms[i].q = 0; ms[i].ql = 0; end
        end else if (ss) begin
            ms[i].q = 1; ms[i].ql = 0;
        end else if (rs) begin
            ms[i].q = 0; ms[i].ql = 1;
        end else begin
            ms[i].ql = ~ms[i].q;
        end
    endtask

    task automatic cycle(input bit rr, input bit r, input bit s);
        exp_t e;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sb%0d_q", i),    8'(q_w[i]),    8'(e.q[i]));
                check($sformatf("sb%0d_ql", i),   8'(ql_w[i]),   8'(e.ql[i]));
                check($sformatf("sb%0d_inv", i),  8'(inv_w[i]),  8'(e.inv[i]));
                check($sformatf("sb%0d_seen", i), 8'(seen_w[i]), 8'(e.seen[i]));
            end
        end
        rst = rr; R = r; S = s;
        for (int i = 0; i < 4; i++) begin
            model_step(i, rr, r, s);
            e.q[i] = ms[i].q; e.ql[i] = ms[i].ql;
            e.inv[i] = ms[i].inv; e.seen[i] = ms[i].seen;
        end
        sbq.push_back(e);
    endtask

    task automatic hold_pair(input bit r, input bit s, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, r, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; R = 1'b1; S = 1'b1;

        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 0);
        check("rst_q",    8'(q_w[0]),    8'd0);
        check("rst_ql",   8'(ql_w[0]),   8'd1);
        check("rst_inv",  8'(inv_w[0]),  8'd0);
        check("rst_seen", 8'(seen_w[0]), 8'd0);
        hold_pair(1'b1, 1'b0, 9);
        check("rel_q",    8'(q_w[0]),    8'd0);
        check("rel_ql",   8'(ql_w[0]),   8'd1);

        // Basic sequence 10, 00, 01, 11, 00.
        hold_pair(1'b1, 1'b0, 10);
        check("b10_qql", {6'd0, q_w[0], ql_w[0]}, 8'b01);
        hold_pair(1'b0, 1'b0, 10);
        check("b00_qql", {6'd0, q_w[0], ql_w[0]}, 8'b01);
        hold_pair(1'b0, 1'b1, 10);
        check("b01_qql", {6'd0, q_w[0], ql_w[0]}, 8'b10);
        hold_pair(1'b1, 1'b1, 10);
        check("b11_qql", {6'd0, q_w[0], ql_w[0]}, 8'b00);
        check("b11_inv", 8'(inv_w[0]), 8'd1);
        hold_pair(1'b0, 1'b0, 10);
        check("b00i_qql",  {6'd0, q_w[0], ql_w[0]}, 8'b01);
        check("b00i_inv",  8'(inv_w[0]),  8'd0);
        check("b00i_seen", 8'(seen_w[0]), 8'd1);

        // Hold after set, every cycle.
        hold_pair(1'b0, 1'b1, 10);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("hold_qql", {6'd0, q_w[0], ql_w[0]}, 8'b10);
        end

        // Reset-dominant from Q=1, set-dominant from Q=0.
        hold_pair(1'b0, 1'b1, 10);
        hold_pair(1'b1, 1'b1, 10);
        check("m1_qql", {6'd0, q_w[1], ql_w[1]}, 8'b01);
        check("m1_inv", 8'(inv_w[1]), 8'd1);
        hold_pair(1'b1, 1'b0, 10);
        hold_pair(1'b1, 1'b1, 10);
        check("m2_qql", {6'd0, q_w[2], ql_w[2]}, 8'b10);
        check("m2_inv", 8'(inv_w[2]), 8'd1);

        // Single-cycle S pulse through a two-stage synchronizer.
        hold_pair(1'b1, 1'b0, 10);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("sync_e1", 8'(q_w[3]), 8'd0);
        check("pulse0",  8'(q_w[0]), 8'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("sync_e2", 8'(q_w[3]), 8'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("sync_e3", 8'(q_w[3]), 8'd1);
        hold_pair(1'b0, 1'b0, 5);

        // Reset in the middle of a forbidden sequence.
        hold_pair(1'b1, 1'b1, 10);
        check("ri_inv_pre", 8'(inv_w[0]), 8'd1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("ri_qql",  {6'd0, q_w[0], ql_w[0]}, 8'b01);
        check("ri_inv",  8'(inv_w[0]),  8'd0);
        check("ri_seen", 8'(seen_w[0]), 8'd0);
        cycle(1'b0, 1'b1, 1'b1);
        check("ri_inv_post", 8'(inv_w[0]), 8'd1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_latch.md
# rs_latch

Clocked RS storage element with complementary outputs and an explicit policy for the forbidden R=S=1 input. It reproduces the truth table of a cross-coupled NOR latch (reset, hold, set, invalid) as a synchronous, glitch-free register. Optional input synchronizers and a forbidden-input status flag make it safe for asynchronous control inputs. It is a leaf cell in the sequential-logic library, used wherever a set/reset flag with a true and a complement output is needed.

## Interface
- SYNC_STAGES, default 0: number of flop stages on R and S before the decode logic.
  - Legal range 0..3.
  - 0 means R and S are sampled directly.
- INVALID_MODE, default 0: behaviour for R=S=1.
  - 0 = NOR-latch behaviour: Q=0 and Q_L=0.
  - 1 = reset-dominant.
  - 2 = set-dominant.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- R  input  1  reset request, active-high.
- S  input  1  set request, active-high.
- Q  output  1  stored value.
- Q_L  output  1  complement output; equals ~Q except in the INVALID_MODE 0 forbidden state.
- INV  output  1  high for every cycle in which the decoded input pair is R=S=1.
- INV_SEEN  output  1  sticky; set on the first forbidden cycle, cleared only by rst.

## Operation
- R and S pass through SYNC_STAGES flops. These flops are cleared to 0 by rst. Call the synchronized values Rs and Ss.
- Decode per clock edge (rst low), using Rs and Ss:
  - Rs=0, Ss=0 (HOLD): state unchanged.
  - Rs=0, Ss=1 (SET): state<=1, Q=1, Q_L=0.
  - Rs=1, Ss=0 (RESET): state<=0, Q=0, Q_L=1.
  - Rs=1, Ss=1 (INVALID), by INVALID_MODE:
    - 0: state<=0 and a registered "both-low" flag is set, giving Q=0 and Q_L=0.
    - 1: treated as RESET.
    - 2: treated as SET.
    - In every mode INV<=1 and INV_SEEN<=1.
- Leaving INVALID in mode 0: the both-low flag clears on the next non-invalid decode.
  - From INVALID to HOLD: outputs resolve to the stored state 0, so Q=0 and Q_L=1. The race of the analog latch is resolved deterministically to reset.
  - From INVALID to SET: Q=1, Q_L=0.
  - From INVALID to RESET: Q=0, Q_L=1.
- INV is 0 on any non-invalid decode.
- INVALID_MODE values other than 0..2 behave as 0.
- All outputs come straight from flops; there are no combinational paths from the inputs to the outputs.

## Timing
- Latency: an input change is visible on Q, Q_L and INV after SYNC_STAGES+1 rising edges.
- rst high at a rising edge forces the following, overriding any R/S value:
  - Q=0, Q_L=1, INV=0, INV_SEEN=0.
  - Synchronizer flops cleared.
  - Both-low flag cleared.
- Reset mid-operation, including in the middle of a forbidden sequence: the reset values appear on the next edge.
- The first decode after rst is released uses the first sample of R/S taken with rst low, delayed by the synchronizer depth.
- Single-cycle pulses on R or S are captured. Pulses that do not span a rising edge are ignored.
- The flops after the synchronizers have no metastability requirement. The synchronizers carry the standard async-crossing attribute when SYNC_STAGES≥2.

## Test plan
All scenarios use SYNC_STAGES=0, INVALID_MODE=0, and hold each input pair for 10 clocks unless stated otherwise.
- Reset behaviour: rst=1 for 2 clocks with R=1, S=1, then R=1, S=0 → Q=0, Q_L=1, INV=0, INV_SEEN=0.
- Basic sequence: R/S pairs 10, 00, 01, 11, 00 → required Q/Q_L after each step:
  - 10: 0/1.
  - 00: 0/1 (held).
  - 01: 1/0.
  - 11: 0/0 with INV=1.
  - 00: 0/1 with INV=0 and INV_SEEN=1.
- Hold after set: SET, then 00 for 20 clocks → Q stays 1, Q_L stays 0 for all 20 clocks.
- Other invalid policies:
  - INVALID_MODE=1, from Q=1, apply 11 → Q=0, Q_L=1, INV=1.
  - INVALID_MODE=2, from Q=0, apply 11 → Q=1, Q_L=0, INV=1.
- Synchronizer latency: SYNC_STAGES=2, a 1-clock S pulse → Q rises exactly 3 edges after the pulse is sampled.
- Reset during invalid: apply 11, then rst pulse while 11 is still applied → Q=0, Q_L=1, INV=0, INV_SEEN=0 on the edge after rst. INV returns to 1 one edge after rst drops.
